bars_gen: RTL

Parametrised, registered VGA test-pattern generator: the next generation of the fixed 8-bar colour source. It sits between the VGA sync/timing controller and the colour output pins. It tracks the pixel position with internal counters instead of comparators, so bar count and colour depth are free parameters. Four frame-synchronous modes are selectable: vertical bars, horizontal bars, checkerboard and scrolling bars.

---
 rtl/bars_gen_if.sv | 23 ++
 rtl/bars_gen.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bars_gen_if.sv
// rtl/bars_gen_if.sv - pixel position in, pattern colour out, between timing controller and bars_gen
interface bars_gen_if #(
  parameter int CW = 3
);
  logic [9:0]    x_px;
  logic [9:0]    y_px;
  logic          activevideo;
  logic [1:0]    mode;
  logic [CW-1:0] color_px;
  logic          color_valid;

  // timing-controller side
  modport master (
    output x_px, y_px, activevideo, mode,
    input  color_px, color_valid
  );

  // pattern-generator side
  modport slave (
    input  x_px, y_px, activevideo, mode,
    output color_px, color_valid
  );
endinterface

// File: rtl/bars_gen.sv
// rtl/bars_gen.sv - registered VGA test-pattern generator (vertical/horizontal/checker/scroll)
module bars_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int NBARS     = 8,
  parameter int CW        = 3,
  parameter int FRAME_DIV = 60
) (
  input  logic         clk,
  input  logic         rst,
  bars_gen_if.slave    bus
);

  localparam int BARW = H_ACTIVE / NBARS;
  localparam int BARH = V_ACTIVE / NBARS;
  // bar indices run 0..NBARS, NBARS marking the remainder region past the last full bar
  localparam int BW   = $clog2(NBARS + 1);
  localparam int HCW  = $clog2(BARW + 1);
  localparam int VCW  = $clog2(BARH + 1);
  localparam int FW   = $clog2(FRAME_DIV + 1);

  localparam logic [BW-1:0]  NB      = BW'(NBARS);
  localparam logic [BW-1:0]  NB_M1   = BW'(NBARS - 1);
  localparam logic [BW:0]    NB_X    = (BW + 1)'(NBARS);
  localparam logic [HCW-1:0] BARW_M1 = HCW'(BARW - 1);
  localparam logic [VCW-1:0] BARH_M1 = VCW'(BARH - 1);
  localparam logic [FW-1:0]  FD_M1   = FW'(FRAME_DIV - 1);

  // bar k is drawn in the inverse of its low index bits: bar 0 is all-ones
  function automatic logic [CW-1:0] bar_color(input logic [BW-1:0] k);
    return ~(CW'(k));
  endfunction

  logic [BW-1:0]  hbar_q, hbar_d, vbar_q, vbar_d, off_q, off_d, sidx;
  logic [HCW-1:0] hcnt_q, hcnt_d;
  logic [VCW-1:0] vcnt_q, vcnt_d;
  logic [FW-1:0]  fcnt_q, fcnt_d;
  logic [1:0]     mode_q, mode_d;
  logic [CW-1:0]  color_q, color_d, pix;
  logic           valid_q;
  logic [BW:0]    sum;
  logic           x_zero, y_zero, fs, h_in, v_in;

  assign x_zero = (bus.x_px == '0);
  assign y_zero = (bus.y_px == '0);
  assign fs     = bus.activevideo & x_zero & y_zero;

  // position tracking by counters, plus frame-start sampling of mode, frame count and scroll offset
  always_comb begin
    hbar_d = hbar_q;
    hcnt_d = hcnt_q;
    vbar_d = vbar_q;
    vcnt_d = vcnt_q;
    mode_d = mode_q;
    fcnt_d = fcnt_q;
    off_d  = off_q;
    if (bus.activevideo) begin
      if (x_zero) begin
        hbar_d = '0;
        hcnt_d = '0;
        if (y_zero) begin
          vbar_d = '0;
          vcnt_d = '0;
        end else if (vcnt_q == BARH_M1) begin
          vcnt_d = '0;
          if (vbar_q != NB) vbar_d = vbar_q + BW'(1);
        end else begin
          vcnt_d = vcnt_q + VCW'(1);
        end
      end else if (hcnt_q == BARW_M1) begin
        hcnt_d = '0;
        if (hbar_q != NB) hbar_d = hbar_q + BW'(1);
      end else begin
        hcnt_d = hcnt_q + HCW'(1);
      end
    end
    if (fs) begin
      mode_d = bus.mode;
      if (fcnt_q == FD_M1) begin
        fcnt_d = '0;
        off_d  = (off_q == NB_M1) ? '0 : off_q + BW'(1);
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // colour of the current pixel, using the freshly updated indices, mode and offset
  always_comb begin
    h_in = (hbar_d < NB);
    v_in = (vbar_d < NB);
    sum  = {1'b0, hbar_d} + {1'b0, off_d};
    sidx = (sum >= NB_X) ? BW'(sum - NB_X) : BW'(sum);
    pix  = '0;
    case (mode_d)
      2'd0:    pix = h_in ? bar_color(hbar_d) : '0;
      2'd1:    pix = v_in ? bar_color(vbar_d) : '0;
      2'd2:    pix = (h_in && v_in && !(hbar_d[0] ^ vbar_d[0])) ? '1 : '0;
      default: pix = h_in ? bar_color(sidx) : '0;
    endcase
    color_d = bus.activevideo ? pix : '0;
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hbar_q  <= '0;
      hcnt_q  <= '0;
      vbar_q  <= '0;
      vcnt_q  <= '0;
      mode_q  <= '0;
      fcnt_q  <= '0;
      off_q   <= '0;
      color_q <= '0;
      valid_q <= 1'b0;
    end else begin
      hbar_q  <= hbar_d;
      hcnt_q  <= hcnt_d;
      vbar_q  <= vbar_d;
      vcnt_q  <= vcnt_d;
      mode_q  <= mode_d;
      fcnt_q  <= fcnt_d;
      off_q   <= off_d;
      color_q <= color_d;
      valid_q <= bus.activevideo;
    end
  end

  assign bus.color_px    = color_q;
  assign bus.color_valid = valid_q;

endmodule
